// File: rtl/pc_redirect_ctrl_if.sv
// Handshake bundle between the EX-stage branch resolver / IF stage and pc_redirect_ctrl.
// The master drives the resolution inputs; the slave (the controller) returns PC and flush controls.
interface pc_redirect_ctrl_if #(
    parameter int PC_W = 9
);
    logic            stall;
    logic            ex_valid;
    logic            br_taken;
    logic            jump;
    logic [31:0]     br_pc;
    logic [PC_W-1:0] pc;
    logic            redirect;
    logic            if_id_flush;
    logic            id_ex_flush;
    logic            busy;
    logic            misalign_err;

    modport master (
        output stall, ex_valid, br_taken, jump, br_pc,
        input  pc, redirect, if_id_flush, id_ex_flush, busy, misalign_err
    );

    modport slave (
        input  stall, ex_valid, br_taken, jump, br_pc,
        output pc, redirect, if_id_flush, id_ex_flush, busy, misalign_err
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: sequential increment, EX-stage redirects, deferred redirect under stall, wrong-path squash.
// Optional MISALIGN_CHK_EN: misaligned targets vector to TRAP_VEC and set a sticky misalign_err.
module pc_redirect_ctrl #(
    parameter int              PC_W      = 9,
    parameter int              FLUSH_CYC = 2,
    parameter logic [PC_W-1:0] TRAP_VEC  = 9'h1F0
) (
    input  logic             clk,
    input  logic             reset,
    pc_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, PEND, FLUSH} state_e;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYC);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_q, pend_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            merr_q, merr_d;

    logic            req;
    logic            misalign;
    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] pc_inc;
    logic            redirect;

    assign req      = bus.ex_valid && (bus.br_taken || bus.jump);
    assign misalign = |bus.br_pc[1:0];
    assign pc_inc   = pc_q + PC_W'(4);

`ifdef MISALIGN_CHK_EN
    assign tgt = misalign ? TRAP_VEC : {bus.br_pc[PC_W-1:2], 2'b00};
`else
    assign tgt = {bus.br_pc[PC_W-1:2], 2'b00};
`endif

    // Upper target bits are outside the instruction memory and deliberately dropped.
    logic unused_br_bits;
    assign unused_br_bits = ^{bus.br_pc[31:PC_W], misalign};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            merr_q  <= merr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        merr_d   = merr_q;
        redirect = 1'b0;
        case (state_q)
            RUN: begin
                if (req) begin
                    redirect = 1'b1;
`ifdef MISALIGN_CHK_EN
                    merr_d   = merr_q | misalign;
`endif
                    if (bus.stall) begin
                        pend_d  = tgt;
                        state_d = PEND;
                    end else begin
                        pc_d    = tgt;
                        cnt_d   = CNT_INIT;
                        state_d = FLUSH;
                    end
                end else if (!bus.stall) begin
                    pc_d = pc_inc;
                end
            end
            // The frozen EX instruction keeps repeating its request; only stall release matters.
            PEND: begin
                if (!bus.stall) begin
                    pc_d    = pend_q;
                    cnt_d   = CNT_INIT;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!bus.stall) begin
                    pc_d  = pc_inc;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign bus.pc           = pc_q;
    assign bus.redirect     = redirect;
    assign bus.if_id_flush  = (state_q == FLUSH);
    assign bus.id_ex_flush  = (state_q == FLUSH) && (cnt_q == CNT_INIT);
    assign bus.busy         = (state_q != RUN);
`ifdef MISALIGN_CHK_EN
    assign bus.misalign_err = merr_q;
`else
    assign bus.misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed test-plan sequences followed by constrained-random traffic.
module tb_pc_redirect_ctrl;
    localparam int FLUSH_N = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_redirect_ctrl_if #(.PC_W(9)) bus();
    pc_redirect_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int unsigned pc;
        bit rd, ifl, idl, busy, merr;
    } exp_t;
    exp_t q[$];

    int total = 0;
    int bad   = 0;

    // Reference model: outstanding flush cycles, pending target, sticky error.
    int unsigned m_pc = 0, m_pend_tgt = 0;
    bit m_pend = 0, m_first = 0, m_merr = 0;
    int m_left = 0;

    function automatic int unsigned tgt_of(input logic [31:0] b, output bit mis);
        mis = (b % 4) != 0;
`ifdef MISALIGN_CHK_EN
        if (mis) return 32'h1F0;
`endif
        return (b % 512) & ~32'd3;
    endfunction

    task automatic cmp(input string nm, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit rst, input bit st, input bit ev, input bit bt, input bit jp,
                       input logic [31:0] bp);
        exp_t e;
        bit req, mis;
        int unsigned t;
        @(posedge clk); #1;
        reset = rst; bus.stall = st; bus.ex_valid = ev;
        bus.br_taken = bt; bus.jump = jp; bus.br_pc = bp;
        req    = ev && (bt || jp);
        e.pc   = m_pc;
        e.ifl  = m_left > 0;
        e.idl  = m_first;
        e.busy = m_pend || m_left > 0;
        e.rd   = !m_pend && m_left == 0 && req;
        e.merr = m_merr;
        q.push_back(e);
        if (rst) begin
            m_pc = 0; m_pend = 0; m_pend_tgt = 0; m_left = 0; m_first = 0; m_merr = 0;
        end else if (m_left > 0) begin
            if (!st) begin
                m_pc = (m_pc + 4) % 512; m_left--; m_first = 0;
            end
        end else if (m_pend) begin
            if (!st) begin
                m_pc = m_pend_tgt; m_pend = 0; m_left = FLUSH_N; m_first = 1;
            end
        end else if (req) begin
            t = tgt_of(bp, mis);
            if (mis) m_merr = m_merr | `ifdef MISALIGN_CHK_EN 1'b1 `else 1'b0 `endif ;
            if (st) begin
                m_pend = 1; m_pend_tgt = t;
            end else begin
                m_pc = t; m_left = FLUSH_N; m_first = 1;
            end
        end else if (!st) begin
            m_pc = (m_pc + 4) % 512;
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic br(input logic [31:0] bp, input bit st);
        cyc(0, st, 1, 1, 0, bp);
    endtask

    // Directed check of visible outputs shortly after inputs settle.
    task automatic dchk(input int unsigned pc, input bit ifl, input bit idl, input bit busy);
        #1;
        cmp("dir_pc", bus.pc, pc);
        cmp("dir_if_id", bus.if_id_flush, ifl);
        cmp("dir_id_ex", bus.id_ex_flush, idl);
        cmp("dir_busy", bus.busy, busy);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("pc", bus.pc, e.pc);
                cmp("redirect", bus.redirect, e.rd);
                cmp("if_id_flush", bus.if_id_flush, e.ifl);
                cmp("id_ex_flush", bus.id_ex_flush, e.idl);
                cmp("busy", bus.busy, e.busy);
                cmp("misalign_err", bus.misalign_err, e.merr);
                if (bus.if_id_flush && bus.ex_valid) cmp("ex_valid_in_flush", 1, 0);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit st, ev, bt, jp, hold_bt, hold_jp;
        logic [31:0] bp, hold_bp;
        bit exp_merr;
        reset = 1; bus.stall = 0; bus.ex_valid = 0; bus.br_taken = 0; bus.jump = 0; bus.br_pc = 0;
        hold_bt = 0; hold_jp = 0; hold_bp = 0;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        // Sequential fetch from reset.
        idle(); dchk(9'h000, 0, 0, 0);
        idle(); dchk(9'h004, 0, 0, 0);
        idle(); dchk(9'h008, 0, 0, 0);
        // Taken branch without stall.
        br(32'h40, 0); dchk(9'h00C, 0, 0, 0); cmp("dir_redirect", bus.redirect, 1);
        idle(); dchk(9'h040, 1, 1, 1);
        idle(); dchk(9'h044, 1, 0, 1);
        idle(); dchk(9'h048, 0, 0, 0);
        // Position at 0x020, then a jump arriving under a 3-cycle stall.
        br(32'h18, 0); idle(); idle();
        cyc(0, 1, 1, 0, 1, 32'h80); dchk(9'h020, 0, 0, 0); cmp("dir_redirect", bus.redirect, 1);
        cyc(0, 1, 1, 0, 1, 32'h80); dchk(9'h020, 0, 0, 1); cmp("dir_redirect", bus.redirect, 0);
        cyc(0, 1, 1, 0, 1, 32'h80); dchk(9'h020, 0, 0, 1);
        idle(); dchk(9'h020, 0, 0, 1);
        idle(); dchk(9'h080, 1, 1, 1);
        idle(); dchk(9'h084, 1, 0, 1);
        idle(); dchk(9'h088, 0, 0, 0);
        // Wrap of the PC at the top of the address space.
        br(32'h1F0, 0); idle(); idle();
        idle(); dchk(9'h1F8, 0, 0, 0);
        idle(); dchk(9'h1FC, 0, 0, 0);
        idle(); dchk(9'h000, 0, 0, 0);
        // Reset in the first flush cycle.
        br(32'h40, 0);
        cyc(1, 0, 0, 0, 0, 0); dchk(9'h040, 1, 1, 1);
        idle(); dchk(9'h000, 0, 0, 0);
        // Misaligned target; upper bits beyond PC width are ignored.
        br(32'h0000_0C42, 0);
`ifdef MISALIGN_CHK_EN
        idle(); dchk(9'h1F0, 1, 1, 1); exp_merr = 1;
`else
        idle(); dchk(9'h040, 1, 1, 1); exp_merr = 0;
`endif
        cmp("dir_misalign", bus.misalign_err, exp_merr);
        repeat (10) idle();
        #1 cmp("dir_misalign_sticky", bus.misalign_err, exp_merr);

        // Random traffic obeying the front-end protocol.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                cyc(1, 0, 0, 0, 0, 0);
                continue;
            end
            st = $urandom_range(0, 99) < 30;
            bt = $urandom_range(0, 1); jp = $urandom_range(0, 3) == 0;
            bp = $urandom;
            if ($urandom_range(0, 3) != 0) bp[1:0] = 2'b00;
            if (m_left > 0) begin
                ev = 0;
            end else if (m_pend) begin
                st = $urandom_range(0, 99) < 60;
                ev = 1; bt = hold_bt; jp = hold_jp; bp = hold_bp;
                if (!st) ev = $urandom_range(0, 1);
            end else begin
                ev = $urandom_range(0, 1);
                hold_bt = bt; hold_jp = jp; hold_bp = bp;
            end
            cyc(0, st, ev, bt, jp, bp);
        end
        idle();
        @(posedge clk);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) cmp("scoreboard_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
